// File: rtl/rf_access_pkg.sv
// Shared encodings and default widths for the reg_file access engine.
package rf_access_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_FILL  = 2'd0,
        OP_COPY  = 2'd1,
        OP_CHECK = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_COPY  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/rf_addr_seq.sv
// Block address walker: current address, remaining count and a last flag,
// stepping ascending or descending with wrap modulo the address space.
module rf_addr_seq
    import rf_access_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  desc_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  desc_q, desc_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        desc_d = desc_q;
        if (load_i) begin
            // Descending walks start at the top word of the block.
            addr_d = desc_i ? (base_i + len_i[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1)) : base_i;
            cnt_d  = len_i;
            desc_d = desc_i;
        end else if (step_i) begin
            addr_d = desc_q ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
            cnt_d  = cnt_q - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
            desc_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            desc_q <= desc_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == (ADDR_WIDTH+1)'(1));

endmodule

// File: rtl/rf_access_engine.sv
// Block FILL/COPY/CHECK initiator for reg_file. CHECK support is built only
// when RF_ACCESS_CHECK_EN is defined; otherwise op 2 behaves as reserved.
module rf_access_engine
    import rf_access_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_a,
    output logic [ADDR_WIDTH-1:0] rf_rd_a,
    output logic [DATA_WIDTH-1:0] rf_wr_d,
    input  logic [DATA_WIDTH-1:0] rf_rd_d
);

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  pass_q, pass_d;
    logic [DATA_WIDTH-1:0] wr_d_q, wr_d_d;

    logic                  accept;
    logic                  rd_step, wr_step;
    logic                  rd_last, wr_last;
    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [ADDR_WIDTH-1:0] rd_base;
    logic [ADDR_WIDTH-1:0] cmd_off;
    logic                  copy_desc, seq_desc;

    assign accept  = cmd_valid & cmd_ready_q;
    assign rd_base = (op_e'(cmd_op) == OP_COPY) ? cmd_src : cmd_dst;

    // Walk top-down when the destination lands inside the source block, so
    // no source word is overwritten before it is read. A full-space shift by
    // -1 walks upward instead so read and write never share an address.
    assign cmd_off   = cmd_dst - cmd_src;
    assign copy_desc = (cmd_off != '0) && ({1'b0, cmd_off} < cmd_len)
                       && !(cmd_len[ADDR_WIDTH] && (&cmd_off));
    assign seq_desc  = (op_e'(cmd_op) == OP_COPY) && copy_desc;

    rf_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_seq (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .base_i (rd_base),
        .len_i  (cmd_len),
        .desc_i (seq_desc),
        .step_i (rd_step),
        .addr_o (rd_addr),
        .last_o (rd_last)
    );

    rf_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_seq (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .base_i (cmd_dst),
        .len_i  (cmd_len),
        .desc_i (seq_desc),
        .step_i (wr_step),
        .addr_o (wr_addr),
        .last_o (wr_last)
    );

`ifdef RF_ACCESS_CHECK_EN
    logic [DATA_WIDTH-1:0] data_q;
    logic                  cmp_vld_q, cmp_vld_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  mism;

    assign mism = cmp_vld_q && (rf_rd_d != data_q);
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        pass_d      = 1'b0;
        wr_d_d      = wr_d_q;
        rd_step     = 1'b0;
        wr_step     = 1'b0;
`ifdef RF_ACCESS_CHECK_EN
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        cmp_vld_d   = 1'b0;
        cmp_addr_d  = cmp_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_ready_d = 1'b0;
`ifdef RF_ACCESS_CHECK_EN
                    err_d       = 1'b0;
                    err_addr_d  = '0;
`endif
                    if (cmd_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        case (op_e'(cmd_op))
                            OP_FILL: begin
                                state_d = ST_FILL;
                                busy_d  = 1'b1;
                                wr_en_d = 1'b1;
                                wr_d_d  = cmd_data;
                            end
                            OP_COPY: begin
                                state_d = ST_COPY;
                                busy_d  = 1'b1;
                                rd_en_d = 1'b1;
                            end
`ifdef RF_ACCESS_CHECK_EN
                            OP_CHECK: begin
                                state_d = ST_CHECK;
                                busy_d  = 1'b1;
                                rd_en_d = 1'b1;
                            end
`endif
                            default: begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_FILL: begin
                if (wr_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wr_step = 1'b1;
                    wr_en_d = 1'b1;
                end
            end
            ST_COPY: begin
                // Every read issued now becomes next cycle's write.
                wr_en_d = 1'b1;
                pass_d  = 1'b1;
                wr_step = wr_en_q;
                if (rd_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_step = 1'b1;
                    rd_en_d = 1'b1;
                end
            end
`ifdef RF_ACCESS_CHECK_EN
            ST_CHECK: begin
                if (mism) begin
                    err_d      = 1'b1;
                    err_addr_d = cmp_addr_q;
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    cmp_vld_d  = 1'b1;
                    cmp_addr_d = rd_addr;
                    if (rd_last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rd_step = 1'b1;
                        rd_en_d = 1'b1;
                    end
                end
            end
`endif
            ST_DRAIN: begin
`ifdef RF_ACCESS_CHECK_EN
                if (mism) begin
                    err_d      = 1'b1;
                    err_addr_d = cmp_addr_q;
                end
`endif
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            pass_q      <= 1'b0;
            wr_d_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            pass_q      <= pass_d;
            wr_d_q      <= wr_d_d;
        end
    end

`ifdef RF_ACCESS_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            cmp_vld_q  <= cmp_vld_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        cmp_addr_q <= cmp_addr_d;
        if (accept) begin
            data_q <= cmd_data;
        end
    end

    // A read already queued behind the first mismatch is suppressed.
    assign rf_rd_en = rd_en_q & ~((state_q == ST_CHECK) & mism);
    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    assign rf_rd_en = rd_en_q;
    assign err      = 1'b0;
    assign err_addr = '0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rf_wr_en  = wr_en_q;
    assign rf_rd_a   = rd_addr;
    assign rf_wr_a   = wr_addr;
    // COPY forwards read data straight into the write a cycle after the read.
    assign rf_wr_d   = pass_q ? rf_rd_d : wr_d_q;

endmodule

// File: tb/tb_rf_access_engine.sv
// Directed bench for rf_access_engine with a behavioural reg_file and a
// memmove reference memory.
module tb_rf_access_engine;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [8:0]  len;
        logic [31:0] data;
        bit          desc;
        int          exp_k;
        int          exp_act;
        bit          exp_err;
        logic [7:0]  exp_eaddr;
    } cmd_t;

    logic        clk;
    logic        rst;
    logic        tb_init;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_src;
    logic [7:0]  cmd_dst;
    logic [8:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_addr;
    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [7:0]  rf_wr_a;
    logic [7:0]  rf_rd_a;
    logic [31:0] rf_wr_d;
    logic [31:0] rf_rd_d;

    logic [31:0] mem [256];
    logic [31:0] exp_mem [256];
    cmd_t        tbl [13];
    int          tests;
    int          fails;

    rf_access_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_addr  (err_addr),
        .rf_wr_en  (rf_wr_en),
        .rf_rd_en  (rf_rd_en),
        .rf_wr_a   (rf_wr_a),
        .rf_rd_a   (rf_rd_a),
        .rf_wr_d   (rf_wr_d),
        .rf_rd_d   (rf_rd_d)
    );

    always begin
        clk = 1'b0;
        #5;
        clk = 1'b1;
        #5;
    end

    // Behavioural reg_file: synchronous write, registered read data.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
            rf_rd_d <= '0;
        end else begin
            if (rf_wr_en) mem[rf_wr_a] <= rf_wr_d;
            if (rf_rd_en) rf_rd_d <= mem[rf_rd_a];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic mem_check(input string name);
        int d;
        d = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) d++;
        check(name, d, 0);
    endtask

    task automatic run_cmd(input int idx, input cmd_t c);
        int          k, act, same, bad, n;
        bit          dn;
        logic [7:0]  rdq[$];
        logic [7:0]  wrq[$];
        logic [7:0]  er[$];
        logic [7:0]  ew[$];
        logic [7:0]  a8;
        logic [31:0] tmp [256];
        n = int'(c.len);
        @(negedge clk);
        check($sformatf("v%0d_ready_before", idx), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = c.op;
        cmd_src   = c.src;
        cmd_dst   = c.dst;
        cmd_len   = c.len;
        cmd_data  = c.data;
        @(negedge clk);
        cmd_valid = 1'b0;
        check($sformatf("v%0d_busy_k1", idx), busy, (c.exp_k > 1) ? 1 : 0);
        k = 1; dn = 0; act = 0; same = 0;
        while (!dn && k <= 600) begin
            if (rf_rd_en) rdq.push_back(rf_rd_a);
            if (rf_wr_en) wrq.push_back(rf_wr_a);
            if (rf_rd_en || rf_wr_en) act++;
            if (rf_rd_en && rf_wr_en && rf_rd_a == rf_wr_a) same++;
            if (done) dn = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        if (!dn) begin
            check($sformatf("v%0d_done_timeout", idx), 0, 1);
            return;
        end
        check($sformatf("v%0d_done_cycle", idx), k, c.exp_k);
        check($sformatf("v%0d_active_cycles", idx), act, c.exp_act);
        check($sformatf("v%0d_same_addr", idx), same, 0);
        check($sformatf("v%0d_err", idx), err, c.exp_err);
        check($sformatf("v%0d_err_addr", idx), err_addr, c.exp_eaddr);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), {done, busy, cmd_ready}, 3'b001);

        if (c.op == 2'd0) begin
            for (int i = 0; i < n; i++) begin
                a8 = c.dst + 8'(i);
                ew.push_back(a8);
                exp_mem[a8] = c.data;
            end
        end else if (c.op == 2'd1) begin
            for (int i = 0; i < n; i++) tmp[i] = exp_mem[8'(c.src + 8'(i))];
            for (int i = 0; i < n; i++) begin
                a8 = c.desc ? 8'(n - 1 - i) : 8'(i);
                er.push_back(c.src + a8);
                ew.push_back(c.dst + a8);
            end
            for (int i = 0; i < n; i++) exp_mem[8'(c.dst + 8'(i))] = tmp[i];
        end else if (c.op == 2'd2) begin
            for (int i = 0; i < c.exp_act; i++) er.push_back(c.dst + 8'(i));
        end

        bad = (rdq.size() != er.size()) ? 1 : 0;
        for (int i = 0; i < rdq.size() && i < er.size(); i++) if (rdq[i] !== er[i]) bad++;
        check($sformatf("v%0d_rd_addr_seq", idx), bad, 0);
        bad = (wrq.size() != ew.size()) ? 1 : 0;
        for (int i = 0; i < wrq.size() && i < ew.size(); i++) if (wrq[i] !== ew[i]) bad++;
        check($sformatf("v%0d_wr_addr_seq", idx), bad, 0);
        mem_check($sformatf("v%0d_mem", idx));
    endtask

    initial begin
        int   dn_cnt;
        cmd_t c;
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        tb_init   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        cmd_data  = '0;
        for (int i = 0; i < 256; i++) exp_mem[i] = 32'h1000_0000 + i;

        //         op     src    dst    len    data          desc k   act err eaddr
        tbl[0]  = '{2'd0, 8'h00, 8'h10, 9'd4, 32'hA5A5A5A5, 1'b0, 5,  4, 1'b0, 8'h00};
        tbl[1]  = '{2'd1, 8'h00, 8'h40, 9'd8, 32'h0,        1'b0, 10, 9, 1'b0, 8'h00};
        tbl[2]  = '{2'd0, 8'h00, 8'h20, 9'd1, 32'h1,        1'b0, 2,  1, 1'b0, 8'h00};
        tbl[3]  = '{2'd0, 8'h00, 8'h21, 9'd1, 32'h2,        1'b0, 2,  1, 1'b0, 8'h00};
        tbl[4]  = '{2'd0, 8'h00, 8'h22, 9'd1, 32'h3,        1'b0, 2,  1, 1'b0, 8'h00};
        tbl[5]  = '{2'd0, 8'h00, 8'h23, 9'd1, 32'h4,        1'b0, 2,  1, 1'b0, 8'h00};
        tbl[6]  = '{2'd1, 8'h20, 8'h22, 9'd4, 32'h0,        1'b1, 6,  5, 1'b0, 8'h00};
        tbl[7]  = '{2'd0, 8'h00, 8'hFE, 9'd4, 32'h5A5A5A5A, 1'b0, 5,  4, 1'b0, 8'h00};
        tbl[8]  = '{2'd0, 8'h00, 8'h30, 9'd0, 32'hFFFFFFFF, 1'b0, 1,  0, 1'b0, 8'h00};
        tbl[9]  = '{2'd3, 8'h00, 8'h30, 9'd5, 32'hFFFFFFFF, 1'b0, 1,  0, 1'b0, 8'h00};
`ifdef RF_ACCESS_CHECK_EN
        tbl[10] = '{2'd2, 8'h00, 8'h10, 9'd4, 32'hA5A5A5A5, 1'b0, 6,  4, 1'b0, 8'h00};
`else
        tbl[10] = '{2'd2, 8'h00, 8'h10, 9'd4, 32'hA5A5A5A5, 1'b0, 1,  0, 1'b0, 8'h00};
`endif
        tbl[11] = '{2'd0, 8'h00, 8'h12, 9'd1, 32'hDEADBEEF, 1'b0, 2,  1, 1'b0, 8'h00};
`ifdef RF_ACCESS_CHECK_EN
        tbl[12] = '{2'd2, 8'h00, 8'h10, 9'd4, 32'hA5A5A5A5, 1'b0, 5,  3, 1'b1, 8'h12};
`else
        tbl[12] = '{2'd2, 8'h00, 8'h10, 9'd4, 32'hA5A5A5A5, 1'b0, 1,  0, 1'b0, 8'h00};
`endif

        repeat (3) @(negedge clk);
        tb_init = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy_done_err", {busy, done, err}, 3'b000);
        check("rst_enables", {rf_wr_en, rf_rd_en}, 2'b00);
        check("rst_addrs", {err_addr, rf_wr_a, rf_rd_a}, 24'h0);
        check("rst_wr_d", rf_wr_d, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);

        for (int i = 0; i < 13; i++) run_cmd(i, tbl[i]);

        // err/err_addr hold while idle after a failing CHECK
        repeat (3) @(negedge clk);
        check("err_hold", err, tbl[12].exp_err);
        check("err_addr_hold", err_addr, tbl[12].exp_eaddr);

        // Full-space FILL then full-space CHECK
        c = '{2'd0, 8'h00, 8'h80, 9'd256, 32'h0F0F0F0F, 1'b0, 257, 256, 1'b0, 8'h00};
        run_cmd(20, c);
`ifdef RF_ACCESS_CHECK_EN
        c = '{2'd2, 8'h00, 8'h00, 9'd256, 32'h0F0F0F0F, 1'b0, 258, 256, 1'b0, 8'h00};
`else
        c = '{2'd2, 8'h00, 8'h00, 9'd256, 32'h0F0F0F0F, 1'b0, 1, 0, 1'b0, 8'h00};
`endif
        run_cmd(21, c);

        // Reset in the middle of a COPY: the fourth read cycle
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_src   = 8'h00;
        cmd_dst   = 8'h60;
        cmd_len   = 9'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rd_a", {rf_rd_en, rf_wr_en, rf_rd_a}, {2'b11, 8'h03});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_enables", {rf_rd_en, rf_wr_en}, 2'b00);
        check("mid_rst_state", {busy, done, cmd_ready}, 3'b001);
        dn_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dn_cnt++;
        end
        check("mid_rst_no_done", dn_cnt, 0);
        for (int i = 0; i < 3; i++) exp_mem[8'h60 + i] = exp_mem[i];
        mem_check("mid_rst_mem");

        c = '{2'd0, 8'h00, 8'h70, 9'd3, 32'h77777777, 1'b0, 4, 3, 1'b0, 8'h00};
        run_cmd(30, c);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_access_engine.md
Name: rf_access_engine

Overview:
- Command-driven initiator for the reg_file port set (clk, rst, wr_en, rd_en, wr_a, rd_a, wr_d, rd_d).
- Accepts one block command at a time: FILL, COPY or CHECK over a contiguous address range.
- Sequences reg_file reads and writes back-to-back and reports completion and errors.
- Sits between a control/CSR unit and reg_file; replaces hand-driven enable/address sequencing.

Parameters:
DATA_WIDTH, 32, reg_file data width
ADDR_WIDTH, 8, reg_file address width; depth = 2**ADDR_WIDTH

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  engine idle, command accepted when cmd_valid & cmd_ready
cmd_op  in  2  0=FILL, 1=COPY, 2=CHECK, 3=reserved (treated as len 0)
cmd_src  in  ADDR_WIDTH  COPY source base
cmd_dst  in  ADDR_WIDTH  FILL/COPY destination base; CHECK base
cmd_len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
cmd_data  in  DATA_WIDTH  FILL pattern / CHECK expected value
busy  out  1  command in progress
done  out  1  one-cycle pulse at completion
err  out  1  CHECK mismatch flag
err_addr  out  ADDR_WIDTH  address of first mismatch
rf_wr_en  out  1  to reg_file wr_en
rf_rd_en  out  1  to reg_file rd_en
rf_wr_a  out  ADDR_WIDTH  to reg_file wr_a
rf_rd_a  out  ADDR_WIDTH  to reg_file rd_a
rf_wr_d  out  DATA_WIDTH  to reg_file wr_d
rf_rd_d  in  DATA_WIDTH  from reg_file rd_d; valid the cycle after rf_rd_en

Behaviour:
- Reset:
  - outputs registered; state IDLE.
  - cmd_ready=1; busy, done, err, rf_wr_en, rf_rd_en = 0.
  - err_addr, rf_wr_a, rf_rd_a, rf_wr_d = 0.
- States: IDLE, FILL, COPY, CHECK, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept: latch fields, clear err/err_addr, go to op state (len 0 or op 3 -> DONE); cmd_ready=0, busy=1 from next cycle.
- FILL:
  - Each cycle rf_wr_en=1, rf_wr_a=dst+i, rf_wr_d=cmd_data, i=0..len-1.
  - After the last write -> DONE.
  - N cycles of writes.
- COPY:
  - Each cycle rf_rd_en=1, rf_rd_a=src+i.
  - The following cycle rf_wr_en=1, rf_wr_a=dst+i, rf_wr_d=rf_rd_d.
  - Reads and writes overlap in a 1-deep pipeline. After the last read -> DRAIN (final write) -> DONE. N+1 busy-active cycles.
- COPY overlap rule:
  - If dst is in (src, src+len-1] (modulo arithmetic), iterate descending: src+len-1-i / dst+len-1-i.
  - Otherwise iterate ascending.
  - Guarantees memmove semantics.
- CHECK:
  - Reads dst+i each cycle; compares rf_rd_d one cycle later against cmd_data.
  - First mismatch: err=1, err_addr=that address, stop issuing reads, -> DONE.
  - No mismatch: read all N, DRAIN compares the last word, -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, cmd_ready=1 next cycle -> IDLE.
- Arithmetic:
  - Addresses wrap modulo 2**ADDR_WIDTH (e.g. dst=8'hFE, len=4 -> FE,FF,00,01).
  - len = 2**ADDR_WIDTH covers the entire file.
- Holding and handshakes:
  - err/err_addr hold until the next accepted command.
  - cmd_valid while busy is ignored (no queueing).
  - rf_rd_en and rf_wr_en are never asserted to the same address in the same cycle.
- rst mid-operation: rf enables drop at that edge, command abandoned, no done pulse.

Optional Feature:
- Macro: RF_ACCESS_CHECK_EN.
- Defined: CHECK op implemented as above.
- Undefined:
  - CHECK comparator and err/err_addr logic removed.
  - err, err_addr tied 0.
  - op 2 treated as reserved: done pulse one cycle after accept, no reg_file accesses.

Decomposition:
- Shared package rf_access_pkg: op encodings (OP_FILL, OP_COPY, OP_CHECK, OP_RSVD), state encodings, default widths.
- One natural sub-module: rf_addr_seq. It holds the base, count and direction, and produces the current address, the last flag and ascending/descending stepping with wrap. It is instantiated twice (read side, write side).

Test Plan:
- FILL dst=8'h10 len=4 data=32'hA5A5A5A5 -> writes at 10..13 on 4 consecutive cycles; done 1 cycle after last write; readback all A5A5A5A5.
- COPY src=8'h00 dst=8'h40 len=8 after FILL of 00..07 with known data -> 40..47 match; 9 active cycles; done pulse once.
- Overlapping COPY src=8'h20 dst=8'h22 len=4 (20..23 = 1,2,3,4) -> 22..25 = 1,2,3,4 (descending order observed on rf_rd_a).
- Wrap FILL dst=8'hFE len=4 -> writes FE,FF,00,01; len=0 -> done next cycle, no rf enables.
- CHECK dst=8'h10 len=4 data=32'hA5A5A5A5 after corrupting 8'h12 -> err=1, err_addr=8'h12, reads stop after 12; with macro undefined -> err=0, no reads.
- rst asserted mid-COPY at i=3 -> enables low next edge, no done; new FILL accepted afterwards and completes normally.
